// File: rtl/dp_alu_resp.sv
// Datapath responder: accepts an opcode/operand pair on dp_start and returns the result and
// status flags with a one-cycle dp_ready pulse. MUL/DIV/MOD iterate over WIDTH cycles.
module dp_alu_resp #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] dp_A,
  input  logic [WIDTH-1:0] dp_B,
  input  logic [3:0]       dp_op,
  input  logic             dp_start,
  output logic             dp_ready,
  output logic [WIDTH-1:0] dp_result,
  output logic             dp_zero,
  output logic             dp_neg,
  output logic             dp_carry,
  output logic             dp_ovf,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpNot = 4'd5;
  localparam logic [3:0] OpShl = 4'd6;
  localparam logic [3:0] OpShr = 4'd7;
  localparam logic [3:0] OpMul = 4'd8;
  localparam logic [3:0] OpDiv = 4'd9;
  localparam logic [3:0] OpMod = 4'd10;

  typedef enum logic [1:0] {StIdle, StExec, StIter, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // Shared iteration registers: MUL keeps {high partial, low/multiplier}, DIV keeps
  // {remainder, quotient-in-progress}.
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic             ready_q, ready_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  // Single-cycle ALU
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;

  always_comb begin
    add_sum   = {1'b0, a_q} + {1'b0, b_q};
    sub_diff  = {1'b0, a_q} - {1'b0, b_q};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op_q)
      OpAdd: begin
        alu_res   = add_sum[WIDTH-1:0];
        alu_carry = add_sum[WIDTH];
        alu_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpSub: begin
        alu_res   = sub_diff[WIDTH-1:0];
        alu_carry = sub_diff[WIDTH];
        alu_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpAnd: alu_res = a_q & b_q;
      OpOr:  alu_res = a_q | b_q;
      OpXor: alu_res = a_q ^ b_q;
      OpNot: alu_res = ~a_q;
      OpShl: begin
        alu_res   = {a_q[WIDTH-2:0], 1'b0};
        alu_carry = a_q[WIDTH-1];
      end
      OpShr: begin
        alu_res   = {1'b0, a_q[WIDTH-1:1]};
        alu_carry = a_q[0];
      end
      default: begin
        alu_res = '0;
        alu_ovf = 1'b1;
      end
    endcase
  end

  // One iteration step of shift-add multiply and restoring divide
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ok;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;

  always_comb begin
    mul_sum   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, b_q}) : {1'b0, hi_q};
    mul_next  = {mul_sum, lo_q[WIDTH-1:1]};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, b_q});
    rem_next  = div_ok ? WIDTH'(div_shift - {1'b0, b_q}) : div_shift[WIDTH-1:0];
    quo_next  = {lo_q[WIDTH-2:0], div_ok};
  end

  // Control FSM and result capture
  logic             start_iter;
  logic             fin;
  logic [WIDTH-1:0] fin_res;
  logic             fin_carry;
  logic             fin_ovf;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    result_d  = result_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    ready_d   = 1'b0;
    fin       = 1'b0;
    fin_res   = '0;
    fin_carry = 1'b0;
    fin_ovf   = 1'b0;
    start_iter = (dp_op == OpMul) || (dp_op == OpDiv) || (dp_op == OpMod);

    unique case (state_q)
      // DONE accepts a start like IDLE so back-to-back ops issue every other cycle.
      StIdle, StDone: begin
        state_d = StIdle;
        if (dp_start) begin
          a_d  = dp_A;
          b_d  = dp_B;
          op_d = dp_op;
          if (start_iter) begin
            state_d = StIter;
            cnt_d   = CntW'(WIDTH);
            hi_d    = '0;
            lo_d    = dp_A;
          end else begin
            state_d = StExec;
          end
        end
      end
      StExec: begin
        fin       = 1'b1;
        fin_res   = alu_res;
        fin_carry = alu_carry;
        fin_ovf   = alu_ovf;
        state_d   = StDone;
      end
      StIter: begin
        cnt_d = cnt_q - CntW'(1);
        if (op_q == OpMul) begin
          hi_d = mul_next[2*WIDTH-1:WIDTH];
          lo_d = mul_next[WIDTH-1:0];
        end else begin
          hi_d = rem_next;
          lo_d = quo_next;
        end
        if (cnt_q == CntW'(1)) begin
          fin     = 1'b1;
          state_d = StDone;
          if (op_q == OpMul) begin
            fin_res   = mul_next[WIDTH-1:0];
            fin_carry = |mul_next[2*WIDTH-1:WIDTH];
            fin_ovf   = |mul_next[2*WIDTH-1:WIDTH];
          end else if (b_q == '0) begin
            fin_res = (op_q == OpDiv) ? '1 : a_q;
            fin_ovf = 1'b1;
          end else begin
            fin_res = (op_q == OpDiv) ? quo_next : rem_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (fin) begin
      result_d = fin_res;
      zero_d   = (fin_res == '0);
      neg_d    = fin_res[WIDTH-1];
      carry_d  = fin_carry;
      ovf_d    = fin_ovf;
      ready_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign dp_ready  = ready_q;
  assign dp_result = result_q;
  assign dp_zero   = zero_q;
  assign dp_neg    = neg_q;
  assign dp_carry  = carry_q;
  assign dp_ovf    = ovf_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dp_alu_resp.sv
// Self-checking bench for dp_alu_resp: directed cases, then randomized ops against an
// arithmetic reference model, with latency, pulse width and abort behaviour checked.
module tb_dp_alu_resp;

  localparam int W = 8;

  logic         clk;
  logic         rstn;
  logic [W-1:0] dp_A;
  logic [W-1:0] dp_B;
  logic [3:0]   dp_op;
  logic         dp_start;
  logic         dp_ready;
  logic [W-1:0] dp_result;
  logic         dp_zero;
  logic         dp_neg;
  logic         dp_carry;
  logic         dp_ovf;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;

  dp_alu_resp #(.WIDTH(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .dp_A     (dp_A),
    .dp_B     (dp_B),
    .dp_op    (dp_op),
    .dp_start (dp_start),
    .dp_ready (dp_ready),
    .dp_result(dp_result),
    .dp_zero  (dp_zero),
    .dp_neg   (dp_neg),
    .dp_carry (dp_carry),
    .dp_ovf   (dp_ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the opcode table, using integer arithmetic.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic c, output logic v);
    int unsigned ua;
    int unsigned ub;
    int          sa;
    int          sb;
    int          s;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    r  = '0;
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      4'd0: begin
        r = W'(ua + ub);
        c = (ua + ub) > 255;
        s = sa + sb;
        v = (s > 127) || (s < -128);
      end
      4'd1: begin
        r = W'(ua - ub);
        c = ua < ub;
        s = sa - sb;
        v = (s > 127) || (s < -128);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin r = W'(ua * 2); c = (ua >= 128); end
      4'd7: begin r = W'(ua / 2); c = (ua % 2) == 1; end
      4'd8: begin
        r = W'(ua * ub);
        c = (ua * ub) > 255;
        v = c;
      end
      4'd9: begin
        if (ub == 0) begin r = 8'hFF; v = 1'b1; end
        else r = W'(ua / ub);
      end
      4'd10: begin
        if (ub == 0) begin r = a; v = 1'b1; end
        else r = W'(ua % ub);
      end
      default: v = 1'b1;
    endcase
  endtask

  // Issue one op from just after a clock edge; scramble inputs while it runs and
  // optionally pulse dp_start again at cycle inject_k (must be ignored).
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inject_k);
    logic [W-1:0] er;
    logic         ec;
    logic         ev;
    int           lat;
    int           early;
    model(op, a, b, er, ec, ev);
    lat      = (op == 4'd8 || op == 4'd9 || op == 4'd10) ? W : 1;
    dp_op    = op;
    dp_A     = a;
    dp_B     = b;
    dp_start = 1'b1;
    @(posedge clk);
    #1;
    dp_start = 1'b0;
    early    = 0;
    for (int k = 1; k <= lat; k++) begin
      dp_A     = W'($urandom);
      dp_B     = W'($urandom);
      dp_op    = (inject_k > 0) ? 4'd0 : 4'($urandom);
      dp_start = (k == inject_k);
      @(posedge clk);
      #1;
      check("busy", {15'd0, busy}, 16'd1);
      if (k < lat && dp_ready) early++;
    end
    dp_start = 1'b0;
    check("early_ready", 16'(early), 16'd0);
    check("ready", {15'd0, dp_ready}, 16'd1);
    check("result", {8'd0, dp_result}, {8'd0, er});
    check("flags", {12'd0, dp_zero, dp_neg, dp_carry, dp_ovf},
          {12'd0, (er == 8'd0), er[W-1], ec, ev});
    @(posedge clk);
    #1;
    check("ready_width", {15'd0, dp_ready}, 16'd0);
    check("busy_idle", {15'd0, busy}, 16'd0);
    check("result_hold", {8'd0, dp_result}, {8'd0, er});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    rstn     = 1'b0;
    dp_A     = '0;
    dp_B     = '0;
    dp_op    = '0;
    dp_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {3'd0, dp_ready, dp_result, dp_zero, dp_neg, dp_carry, dp_ovf, busy},
          16'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_outputs",
          {3'd0, dp_ready, dp_result, dp_zero, dp_neg, dp_carry, dp_ovf, busy}, 16'd0);

    // Directed cases
    run_op(4'd0,  8'h7F, 8'h01, 0);
    run_op(4'd1,  8'h05, 8'h07, 0);
    run_op(4'd1,  8'h33, 8'h33, 0);
    run_op(4'd8,  8'h10, 8'h11, 0);
    run_op(4'd8,  8'h0F, 8'h03, 0);
    run_op(4'd9,  8'h64, 8'h07, 0);
    run_op(4'd10, 8'h64, 8'h07, 0);
    run_op(4'd9,  8'h20, 8'h00, 0);
    run_op(4'd10, 8'h20, 8'h00, 0);
    run_op(4'd15, 8'hA5, 8'h5A, 0);
    run_op(4'd6,  8'h81, 8'h00, 0);
    run_op(4'd7,  8'h03, 8'h00, 0);

    // MUL with a stray ADD start 3 cycles in: one pulse, MUL result
    run_op(4'd8, 8'h10, 8'h11, 3);

    // Back-to-back: start held over E+1 is ignored, start at E+2 is accepted
    dp_op    = 4'd0;
    dp_A     = 8'h01;
    dp_B     = 8'h02;
    dp_start = 1'b1;
    @(posedge clk);
    #1;
    dp_A = 8'h10;
    dp_B = 8'h20;
    @(posedge clk);
    #1;
    check("b2b_first_ready", {15'd0, dp_ready}, 16'd1);
    check("b2b_first_result", {8'd0, dp_result}, 16'h0003);
    dp_A = 8'h05;
    dp_B = 8'h06;
    @(posedge clk);
    #1;
    dp_start = 1'b0;
    check("b2b_gap", {15'd0, dp_ready}, 16'd0);
    @(posedge clk);
    #1;
    check("b2b_second_ready", {15'd0, dp_ready}, 16'd1);
    check("b2b_second_result", {8'd0, dp_result}, 16'h000B);
    @(posedge clk);
    #1;
    check("b2b_idle", {15'd0, dp_ready, busy}, 16'd0);

    // Reset during iteration 4 of a DIV aborts with no pulse
    dp_op    = 4'd9;
    dp_A     = 8'h64;
    dp_B     = 8'h07;
    dp_start = 1'b1;
    @(posedge clk);
    #1;
    dp_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("abort_outputs", {3'd0, dp_ready, dp_result, dp_zero, dp_neg, dp_carry, dp_ovf, busy},
          16'd0);
    @(posedge clk);
    #1;
    rstn   = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (dp_ready) pulses++;
    end
    check("abort_no_ready", 16'(pulses), 16'd0);
    run_op(4'd0, 8'h01, 8'h01, 0);

    // Randomized ops, occasionally forcing a zero divisor
    for (int i = 0; i < 60; i++) begin
      logic [3:0]   rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rop = 4'($urandom_range(0, 15));
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
      run_op(rop, ra, rb, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
